// File: rtl/llc_mem_line_serializer_pkg.sv
// Shared types and constants for the LLC memory-line serializer.
package llc_mem_line_serializer_pkg;

   localparam int unsigned SER_WORDS_PER_LINE = 4;
   localparam int unsigned SER_WORD_BITS      = 64;
   localparam int unsigned SER_ADDR_BITS      = 32;
   localparam int unsigned SER_WORD_IDX_BITS  = $clog2(SER_WORDS_PER_LINE);
   localparam int unsigned SER_BYTE_OFF_BITS  = $clog2(SER_WORD_BITS / 8);
   localparam int unsigned SER_LINE_ADDR_BITS = SER_ADDR_BITS - SER_WORD_IDX_BITS - SER_BYTE_OFF_BITS;
   localparam int unsigned SER_LINE_BITS      = SER_WORDS_PER_LINE * SER_WORD_BITS;

   typedef logic [SER_LINE_BITS-1:0]      line_t;
   typedef logic [SER_LINE_ADDR_BITS-1:0] line_addr_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      COLLECT = 2'd2,
      DELIVER = 2'd3
   } llc_mem_ser_state_t;

   typedef struct packed {
      logic                     write;
      logic [SER_ADDR_BITS-1:0] addr;
      logic [2:0]               hsize;
      logic [1:0]               hprot;
      logic [SER_WORD_BITS-1:0] wdata;
   } mem_beat_req_t;

   typedef struct packed {
      logic [SER_WORD_BITS-1:0] rdata;
   } mem_beat_rsp_t;

endpackage

// File: rtl/llc_mem_line_assembler.sv
// Collects in-order read words into line slots and tracks how many have arrived.
module llc_mem_line_assembler
   import llc_mem_line_serializer_pkg::*;
#(
   parameter int unsigned WORDS_PER_LINE = SER_WORDS_PER_LINE,
   parameter int unsigned WORD_BITS      = SER_WORD_BITS,
   parameter int unsigned CNT_BITS       = $clog2(WORDS_PER_LINE) + 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic                                enable,
   input  logic [CNT_BITS-1:0]                 limit,
   input  logic                                rsp_valid,
   input  logic [WORD_BITS-1:0]                rsp_rdata,
   output logic                                rsp_ready,
   output logic                                word_last,
   output logic                                full,
   output logic [WORDS_PER_LINE*WORD_BITS-1:0] line
);

   localparam int unsigned         IDX_BITS = $clog2(WORDS_PER_LINE);
   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WORDS_PER_LINE - 1);

   logic [WORD_BITS-1:0] slot_r [WORDS_PER_LINE];
   logic [CNT_BITS-1:0]  rsp_cnt_r;
   logic                 full_r;
   logic                 take_s;

   // A word may only be taken once its beat has been (or is being) issued.
   assign rsp_ready = enable && (rsp_cnt_r < limit);
   assign take_s    = rsp_valid && rsp_ready;
   assign word_last = take_s && (rsp_cnt_r == LAST_CNT);
   assign full      = full_r;

   // Slot storage, arrival counter and full flag; cleared at each new line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
            slot_r[i] <= '0;
         end
         rsp_cnt_r <= '0;
         full_r    <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
            slot_r[i] <= '0;
         end
         rsp_cnt_r <= '0;
         full_r    <= 1'b0;
      end else if (take_s) begin
         slot_r[rsp_cnt_r[IDX_BITS-1:0]] <= rsp_rdata;
         rsp_cnt_r                       <= rsp_cnt_r + CNT_BITS'(1);
         if (word_last) begin
            full_r <= 1'b1;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < int'(WORDS_PER_LINE); g++) begin : g_pack
         assign line[g*WORD_BITS +: WORD_BITS] = slot_r[g];
      end
   endgenerate

endmodule

// File: rtl/llc_mem_line_serializer.sv
// Splits one LLC line request into word beats; reassembles fill data into a line.
module llc_mem_line_serializer
   import llc_mem_line_serializer_pkg::*;
#(
   parameter int unsigned WORDS_PER_LINE = SER_WORDS_PER_LINE,
   parameter int unsigned WORD_BITS      = SER_WORD_BITS,
   parameter int unsigned ADDR_BITS      = SER_ADDR_BITS,
   parameter int unsigned LINE_ADDR_BITS = ADDR_BITS - $clog2(WORDS_PER_LINE) - $clog2(WORD_BITS / 8)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                llc_mem_req_valid,
   output logic                                llc_mem_req_ready,
   input  logic                                llc_mem_req_data_hwrite,
   input  logic [2:0]                          llc_mem_req_data_hsize,
   input  logic [1:0]                          llc_mem_req_data_hprot,
   input  logic [LINE_ADDR_BITS-1:0]           llc_mem_req_data_addr,
   input  logic [WORDS_PER_LINE*WORD_BITS-1:0] llc_mem_req_data_line,
   output logic                                llc_mem_rsp_valid,
   input  logic                                llc_mem_rsp_ready,
   output logic [WORDS_PER_LINE*WORD_BITS-1:0] llc_mem_rsp_data_line,
   output logic                                mem_beat_req_valid,
   input  logic                                mem_beat_req_ready,
   output logic                                mem_beat_req_write,
   output logic [ADDR_BITS-1:0]                mem_beat_req_addr,
   output logic [2:0]                          mem_beat_req_hsize,
   output logic [1:0]                          mem_beat_req_hprot,
   output logic [WORD_BITS-1:0]                mem_beat_req_wdata,
   input  logic                                mem_beat_rsp_valid,
   output logic                                mem_beat_rsp_ready,
   input  logic [WORD_BITS-1:0]                mem_beat_rsp_rdata,
   output logic                                busy
);

   localparam int unsigned         IDX_BITS  = $clog2(WORDS_PER_LINE);
   localparam int unsigned         OFF_BITS  = $clog2(WORD_BITS / 8);
   localparam int unsigned         CNT_BITS  = IDX_BITS + 1;
   localparam int unsigned         LINE_BITS = WORDS_PER_LINE * WORD_BITS;
   localparam logic [CNT_BITS-1:0] LAST_CNT  = CNT_BITS'(WORDS_PER_LINE - 1);

   llc_mem_ser_state_t        state_r;
   llc_mem_ser_state_t        state_nx_s;
   logic                      req_ready_r;
   logic                      write_r;
   logic [2:0]                hsize_r;
   logic [1:0]                hprot_r;
   logic [LINE_ADDR_BITS-1:0] addr_r;
   logic [LINE_BITS-1:0]      line_r;
   logic [CNT_BITS-1:0]       issue_cnt_r;

   logic                      accept_s;
   logic                      beat_valid_s;
   logic                      beat_hs_s;
   logic                      last_beat_s;
   logic                      collect_s;
   logic                      deliver_s;
   logic [CNT_BITS-1:0]       limit_s;
   logic [WORD_BITS-1:0]      wdata_s;
   logic [WORD_BITS-1:0]      words_s [WORDS_PER_LINE];
   logic                      word_last_s;
   logic                      full_s;

   assign accept_s    = llc_mem_req_valid && req_ready_r && (state_r == IDLE);
   assign beat_hs_s   = beat_valid_s && mem_beat_req_ready;
   assign last_beat_s = beat_hs_s && (issue_cnt_r == LAST_CNT);
   assign limit_s     = issue_cnt_r + CNT_BITS'(beat_hs_s);

   // State-decoded strobes; collection is only enabled for fills.
   always_comb begin
      beat_valid_s = 1'b0;
      collect_s    = 1'b0;
      deliver_s    = 1'b0;
      case (state_r)
         IDLE: begin
            beat_valid_s = 1'b0;
         end
         ISSUE: begin
            beat_valid_s = 1'b1;
            collect_s    = !write_r;
         end
         COLLECT: begin
            collect_s = 1'b1;
         end
         DELIVER: begin
            deliver_s = 1'b1;
         end
         default: begin
            beat_valid_s = 1'b0;
         end
      endcase
   end

   // Next-state selection for the line transaction.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nx_s = ISSUE;
            else          state_nx_s = IDLE;
         end
         ISSUE: begin
            if (last_beat_s) begin
               if (write_r)                        state_nx_s = IDLE;
               else if (word_last_s || full_s)     state_nx_s = DELIVER;
               else                                state_nx_s = COLLECT;
            end else begin
               state_nx_s = ISSUE;
            end
         end
         COLLECT: begin
            if (word_last_s) state_nx_s = DELIVER;
            else             state_nx_s = COLLECT;
         end
         DELIVER: begin
            if (llc_mem_rsp_ready) state_nx_s = IDLE;
            else                   state_nx_s = DELIVER;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register; request ready is registered so it stays low through reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         req_ready_r <= (state_nx_s == IDLE);
      end
   end

   // Request latch, captured once per accepted line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_r <= 1'b0;
         hsize_r <= 3'd0;
         hprot_r <= 2'd0;
         addr_r  <= '0;
         line_r  <= '0;
      end else if (accept_s) begin
         write_r <= llc_mem_req_data_hwrite;
         hsize_r <= llc_mem_req_data_hsize;
         hprot_r <= llc_mem_req_data_hprot;
         addr_r  <= llc_mem_req_data_addr;
         line_r  <= llc_mem_req_data_line;
      end
   end

   // Beat counter: cleared on accept, advanced on each beat handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_r <= '0;
      end else if (accept_s) begin
         issue_cnt_r <= '0;
      end else if (beat_hs_s) begin
         issue_cnt_r <= issue_cnt_r + CNT_BITS'(1);
      end
   end

   genvar g;
   generate
      for (g = 0; g < int'(WORDS_PER_LINE); g++) begin : g_words
         assign words_s[g] = line_r[g*WORD_BITS +: WORD_BITS];
      end
   endgenerate

   // Write data of the current beat; reads carry zero.
   always_comb begin
      wdata_s = '0;
      if (write_r) wdata_s = words_s[issue_cnt_r[IDX_BITS-1:0]];
      else         wdata_s = '0;
   end

   llc_mem_line_assembler #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .WORD_BITS      (WORD_BITS),
      .CNT_BITS       (CNT_BITS)
   ) u_assembler (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept_s),
      .enable    (collect_s),
      .limit     (limit_s),
      .rsp_valid (mem_beat_rsp_valid),
      .rsp_rdata (mem_beat_rsp_rdata),
      .rsp_ready (mem_beat_rsp_ready),
      .word_last (word_last_s),
      .full      (full_s),
      .line      (llc_mem_rsp_data_line)
   );

   assign llc_mem_req_ready  = req_ready_r;
   assign llc_mem_rsp_valid  = deliver_s;
   assign mem_beat_req_valid = beat_valid_s;
   assign mem_beat_req_write = write_r;
   assign mem_beat_req_addr  = {addr_r, issue_cnt_r[IDX_BITS-1:0], {OFF_BITS{1'b0}}};
   assign mem_beat_req_hsize = hsize_r;
   assign mem_beat_req_hprot = hprot_r;
   assign mem_beat_req_wdata = wdata_s;
   assign busy               = (state_r != IDLE);

endmodule

// File: tb/tb_llc_mem_line_serializer.sv
// Scoreboard bench for the LLC memory-line serializer with a behavioural memory.
module tb_llc_mem_line_serializer;

   localparam int W   = 4;
   localparam int WB  = 64;
   localparam int AB  = 32;
   localparam int LAB = 27;
   localparam int LW  = W * WB;
   localparam int BPW = WB / 8;

   typedef struct {
      logic [AB-1:0] addr;
      logic          write;
      logic [2:0]    hsize;
      logic [1:0]    hprot;
      logic [WB-1:0] wdata;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           llc_mem_req_valid = 1'b0;
   logic           llc_mem_req_ready;
   logic           llc_mem_req_data_hwrite = 1'b0;
   logic [2:0]     llc_mem_req_data_hsize = 3'd0;
   logic [1:0]     llc_mem_req_data_hprot = 2'd0;
   logic [LAB-1:0] llc_mem_req_data_addr = '0;
   logic [LW-1:0]  llc_mem_req_data_line = '0;
   logic           llc_mem_rsp_valid;
   logic           llc_mem_rsp_ready = 1'b1;
   logic [LW-1:0]  llc_mem_rsp_data_line;
   logic           mem_beat_req_valid;
   logic           mem_beat_req_ready = 1'b0;
   logic           mem_beat_req_write;
   logic [AB-1:0]  mem_beat_req_addr;
   logic [2:0]     mem_beat_req_hsize;
   logic [1:0]     mem_beat_req_hprot;
   logic [WB-1:0]  mem_beat_req_wdata;
   logic           mem_beat_rsp_valid = 1'b0;
   logic           mem_beat_rsp_ready;
   logic [WB-1:0]  mem_beat_rsp_rdata = '0;
   logic           busy;

   llc_mem_line_serializer #(
      .WORDS_PER_LINE (W),
      .WORD_BITS      (WB),
      .ADDR_BITS      (AB)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .llc_mem_req_valid       (llc_mem_req_valid),
      .llc_mem_req_ready       (llc_mem_req_ready),
      .llc_mem_req_data_hwrite (llc_mem_req_data_hwrite),
      .llc_mem_req_data_hsize  (llc_mem_req_data_hsize),
      .llc_mem_req_data_hprot  (llc_mem_req_data_hprot),
      .llc_mem_req_data_addr   (llc_mem_req_data_addr),
      .llc_mem_req_data_line   (llc_mem_req_data_line),
      .llc_mem_rsp_valid       (llc_mem_rsp_valid),
      .llc_mem_rsp_ready       (llc_mem_rsp_ready),
      .llc_mem_rsp_data_line   (llc_mem_rsp_data_line),
      .mem_beat_req_valid      (mem_beat_req_valid),
      .mem_beat_req_ready      (mem_beat_req_ready),
      .mem_beat_req_write      (mem_beat_req_write),
      .mem_beat_req_addr       (mem_beat_req_addr),
      .mem_beat_req_hsize      (mem_beat_req_hsize),
      .mem_beat_req_hprot      (mem_beat_req_hprot),
      .mem_beat_req_wdata      (mem_beat_req_wdata),
      .mem_beat_rsp_valid      (mem_beat_rsp_valid),
      .mem_beat_rsp_ready      (mem_beat_rsp_ready),
      .mem_beat_rsp_rdata      (mem_beat_rsp_rdata),
      .busy                    (busy)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   beat_t         exp_beats [$];
   logic [LW-1:0] exp_rsp   [$];
   logic [WB-1:0] pending   [$];
   bit            ready_pat [$];
   logic [WB-1:0] tb_mem    [logic [AB-1:0]];

   bit zl_mode   = 1'b0;
   bit rand_rdy  = 1'b0;
   bit rand_gap  = 1'b0;
   bit rand_rsp  = 1'b0;
   bit hold_rsp  = 1'b0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      checks++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [WB-1:0] mem_word(input logic [AB-1:0] a);
      if (tb_mem.exists(a)) return tb_mem[a];
      return {a ^ 32'hC0DE_F00D, a * 32'h9E37_79B1 + 32'h0000_0001};
   endfunction

   // Model: beat i of line la is at byte address (la*W + i)*BPW; fills return memory words in order.
   task automatic send_req(input logic wr, input logic [LAB-1:0] la, input logic [LW-1:0] line,
                           input logic [2:0] hs, input logic [1:0] hp);
      logic [LW-1:0] exp_line;
      int n;
      exp_line = '0;
      for (int i = 0; i < W; i++) begin
         beat_t b;
         b.addr  = 32'(la) * 32'(W * BPW) + 32'(i * BPW);
         b.write = wr;
         b.hsize = hs;
         b.hprot = hp;
         b.wdata = wr ? line[i*WB +: WB] : '0;
         exp_beats.push_back(b);
         if (!wr) exp_line[i*WB +: WB] = mem_word(b.addr);
      end
      if (!wr) exp_rsp.push_back(exp_line);
      llc_mem_req_valid       = 1'b1;
      llc_mem_req_data_hwrite = wr;
      llc_mem_req_data_addr   = la;
      llc_mem_req_data_line   = line;
      llc_mem_req_data_hsize  = hs;
      llc_mem_req_data_hprot  = hp;
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         if (llc_mem_req_ready) break;
         n++;
      end
      if (n >= 300) fail("req_accept_timeout");
      @(posedge clk);
      #1;
      llc_mem_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(exp_beats.size() == 0 && exp_rsp.size() == 0 && !busy) && n < 1000);
      if (n >= 1000) fail("drain_timeout");
   endtask

   // Memory model: latency-1 in-order responses, or zero-latency responses alongside the beat.
   initial begin
      bit            beat_hs;
      bit            rsp_hs;
      logic [AB-1:0] hs_addr;
      forever begin
         @(negedge clk);
         beat_hs = !rst && mem_beat_req_valid && mem_beat_req_ready && !mem_beat_req_write;
         hs_addr = mem_beat_req_addr;
         rsp_hs  = !rst && mem_beat_rsp_valid && mem_beat_rsp_ready;
         @(posedge clk);
         #1;
         if (rst) begin
            pending.delete();
            mem_beat_req_ready = 1'b0;
            mem_beat_rsp_valid = 1'b0;
         end else begin
            if (rsp_hs && !zl_mode && pending.size() > 0) void'(pending.pop_front());
            if (beat_hs && !zl_mode) pending.push_back(mem_word(hs_addr));
            if (mem_beat_req_valid && ready_pat.size() > 0) mem_beat_req_ready = ready_pat.pop_front();
            else if (rand_rdy) mem_beat_req_ready = ($urandom_range(0, 3) != 0);
            else mem_beat_req_ready = 1'b1;
            if (zl_mode) begin
               mem_beat_rsp_valid = mem_beat_req_valid && mem_beat_req_ready && !mem_beat_req_write;
               mem_beat_rsp_rdata = mem_beat_rsp_valid ? mem_word(mem_beat_req_addr) : '0;
            end else if (pending.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
               mem_beat_rsp_valid = 1'b1;
               mem_beat_rsp_rdata = pending[0];
            end else begin
               mem_beat_rsp_valid = 1'b0;
            end
         end
      end
   end

   // LLC response-side ready driver.
   initial forever begin
      @(posedge clk);
      #1;
      if (hold_rsp)      llc_mem_rsp_ready = 1'b0;
      else if (rand_rsp) llc_mem_rsp_ready = 1'($urandom_range(0, 1));
      else               llc_mem_rsp_ready = 1'b1;
   end

   // Beat monitor: scoreboard compare on handshake, stability check while stalled.
   initial begin
      bit           stall_prev;
      logic [101:0] prev;
      beat_t        e;
      stall_prev = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev)
               check("beat_hold", {mem_beat_req_valid, mem_beat_req_addr, mem_beat_req_write,
                                   mem_beat_req_hsize, mem_beat_req_hprot, mem_beat_req_wdata},
                     {1'b1, prev});
            if (mem_beat_req_valid && mem_beat_req_ready) begin
               if (exp_beats.size() == 0) begin
                  fail("unexpected_beat");
               end else begin
                  e = exp_beats.pop_front();
                  check("beat_addr", mem_beat_req_addr, e.addr);
                  check("beat_ctrl", {mem_beat_req_write, mem_beat_req_hsize, mem_beat_req_hprot},
                        {e.write, e.hsize, e.hprot});
                  check("beat_wdata", mem_beat_req_wdata, e.wdata);
               end
            end
            stall_prev = mem_beat_req_valid && !mem_beat_req_ready;
            prev = {mem_beat_req_addr, mem_beat_req_write, mem_beat_req_hsize,
                    mem_beat_req_hprot, mem_beat_req_wdata};
         end
      end
   end

   // Line response monitor.
   initial forever begin
      @(negedge clk);
      if (!rst && llc_mem_rsp_valid && llc_mem_rsp_ready) begin
         if (exp_rsp.size() == 0) fail("unexpected_rsp");
         else check("rsp_line", llc_mem_rsp_data_line, exp_rsp.pop_front());
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0]  line;
      logic [LAB-1:0] la;
      int n;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      check("rst_req_ready", llc_mem_req_ready, 1'b0);
      check("rst_valids", {mem_beat_req_valid, llc_mem_rsp_valid, mem_beat_rsp_ready}, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_beat_data", {mem_beat_req_addr, mem_beat_req_wdata}, '0);
      check("rst_rsp_line", llc_mem_rsp_data_line, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_before_edge", llc_mem_req_ready, 1'b0);
      @(posedge clk);
      #1;
      check("ready_after_edge", llc_mem_req_ready, 1'b1);

      // Directed fill, memory answering one cycle after each beat
      tb_mem[32'h2460] = 64'h11;
      tb_mem[32'h2468] = 64'h22;
      tb_mem[32'h2470] = 64'h33;
      tb_mem[32'h2478] = 64'h44;
      send_req(1'b0, 27'h0000123, '0, 3'd3, 2'd1);
      drain();

      // Directed write-back to line 5
      line = {64'hD3D3_0000_3333_0003, 64'hD2D2_0000_2222_0002,
              64'hD1D1_0000_1111_0001, 64'hD0D0_0000_0000_0000};
      send_req(1'b1, 27'h5, line, 3'd3, 2'd2);
      n = 0;
      while (!llc_mem_req_ready && n < 50) begin
         check("wb_no_rsp", llc_mem_rsp_valid, 1'b0);
         @(posedge clk);
         #1;
         n++;
      end
      check("wb_ready_latency", n, W);
      drain();

      // Stalling memory ready pattern
      ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      send_req(1'b0, 27'h0ABCDE, '0, 3'd2, 2'd0);
      drain();
      check("ready_pat_consumed", ready_pat.size(), 0);
      ready_pat.delete();

      // Zero-latency memory with the line held back for 5 cycles
      zl_mode  = 1'b1;
      hold_rsp = 1'b1;
      send_req(1'b0, 27'h1F00F0, '0, 3'd3, 2'd3);
      n = 0;
      while (!llc_mem_rsp_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("zl_rsp_latency", n, W);
      for (int k = 0; k < 5; k++) begin
         check("zl_rsp_hold", llc_mem_rsp_valid, 1'b1);
         check("zl_no_accept", llc_mem_req_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      hold_rsp = 1'b0;
      drain();
      zl_mode = 1'b0;

      // Reset in the middle of a fill, after beat 1
      send_req(1'b0, 27'h0000777, '0, 3'd3, 2'd1);
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (mem_beat_req_valid && mem_beat_req_ready && mem_beat_req_addr == 32'h0000_EEE8) break;
         n++;
      end
      if (n >= 50) fail("beat1_timeout");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_valids", {mem_beat_req_valid, llc_mem_rsp_valid, mem_beat_rsp_ready}, 3'b000);
      check("abort_busy", busy, 1'b0);
      exp_beats.delete();
      exp_rsp.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ready_low", llc_mem_req_ready, 1'b0);
      @(posedge clk);
      #1;
      check("abort_ready_high", llc_mem_req_ready, 1'b1);
      check("abort_line_clear", llc_mem_rsp_data_line, '0);
      line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_req(1'b1, 27'h0000777, line, 3'd3, 2'd1);
      drain();
      check("post_abort_line", llc_mem_rsp_data_line, '0);

      // Randomised back-to-back traffic
      rand_rdy = 1'b1;
      rand_gap = 1'b1;
      rand_rsp = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k == 25) begin
            drain();
            zl_mode = 1'b1;
         end
         la   = LAB'($urandom);
         line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         send_req(1'($urandom_range(0, 1)), la, line, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end
      drain();
      zl_mode = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
